// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with run-time limit, wrap/saturate, tc pulse and sticky ovf.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    input  logic             wrap,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_limit,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;

    // Prescaler only advances on cycles that would otherwise be a step; load restarts it.
    always_comb begin
        pre_d = pre_q;
        step  = 1'b0;
        if (load) begin
            pre_d = '0;
        end else if (enable) begin
            if (pre_q == PreLast) begin
                step  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    logic unused_prescale;

    assign step            = enable & ~load;
    assign unused_prescale = ^PRESCALE;
`endif

    always_comb begin
        count_d  = count_q;
        boundary = 1'b0;
        if (load) begin
            count_d = (data > limit) ? limit : data;
        end else if (step) begin
            if (up) begin
                if (count_q >= limit) begin
                    boundary = 1'b1;
                    count_d  = wrap ? '0 : limit;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    boundary = 1'b1;
                    count_d  = wrap ? limit : '0;
                end else if (count_q > limit) begin
                    // Limit was lowered below the count: snap down without flagging.
                    count_d = limit;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // A boundary step sets ovf even when clr_ovf is asserted in the same cycle.
    assign tc_d  = boundary;
    assign ovf_d = boundary | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign at_limit = (count_q == limit);

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: stimulus pushes expected state, a negedge monitor pops and checks.
module tb_counter_mod;

    logic       clk;
    logic       rst, load, enable, up, wrap, clr_ovf;
    logic [7:0] data, limit;
    logic [7:0] count;
    logic       tc, at_limit, ovf;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic       al;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    counter_mod #(
        .WIDTH   (8),
        .PRESCALE(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data    (data),
        .enable  (enable),
        .up      (up),
        .limit   (limit),
        .wrap    (wrap),
        .clr_ovf (clr_ovf),
        .count   (count),
        .tc      (tc),
        .at_limit(at_limit),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs after the falling edge, queue the state expected after the edge.
    task automatic cyc(input logic r, input logic ld, input logic [7:0] d, input logic e,
                       input logic u, input logic [7:0] lim, input logic w, input logic c,
                       input logic [7:0] ec, input logic etc, input logic eovf, input string nm);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; load = ld; data = d; enable = e; up = u; limit = lim; wrap = w; clr_ovf = c;
        @(posedge clk);
        x.cnt  = ec;
        x.tc   = etc;
        x.ovf  = eovf;
        x.al   = (ec == lim);
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: inputs are still those of the finished cycle at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            total++;
            if (count !== x.cnt || tc !== x.tc || ovf !== x.ovf || at_limit !== x.al) begin
                bad++;
                $display("FAIL %s: got count=%0d tc=%b ovf=%b at_limit=%b, want count=%0d tc=%b ovf=%b at_limit=%b",
                         x.name, count, tc, ovf, at_limit, x.cnt, x.tc, x.ovf, x.al);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; load = 0; data = 0; enable = 0; up = 1; limit = 5; wrap = 1; clr_ovf = 0;

        // Reset beats load and enable
        cyc(1, 1, 8'd9, 1, 1, 8'd5, 1, 0, 8'd0, 0, 0, "reset1");
        cyc(1, 1, 8'd9, 1, 1, 8'd5, 1, 0, 8'd0, 0, 0, "reset2");

`ifdef COUNTER_PRESCALE_EN
        // One step every 4 enabled cycles
        for (int i = 0; i < 12; i++)
            cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'((i + 1) / 4), 0, 0, "pre_run");
        cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd3, 0, 0, "pre_hold1");
        cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd3, 0, 0, "pre_hold2");
        cyc(1, 0, 8'd0, 0, 1, 8'd255, 1, 0, 8'd0, 0, 0, "pre_rst");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, (i == 3) ? 8'd1 : 8'd0, 0, 0, "pre_after_rst");
`else
        // Wrap up through limit 5
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd1, 0, 0, "up_wrap1");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd2, 0, 0, "up_wrap2");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd3, 0, 0, "up_wrap3");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd4, 0, 0, "up_wrap4");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd5, 0, 0, "up_wrap5");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd0, 1, 1, "up_wrap_tc");
        cyc(0, 0, 8'd0, 1, 1, 8'd5, 1, 0, 8'd1, 0, 1, "up_wrap7");

        // Saturating down count
        cyc(0, 1, 8'd2, 0, 0, 8'd5, 0, 0, 8'd2, 0, 1, "dn_load");
        cyc(0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 8'd1, 0, 1, "dn1");
        cyc(0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 8'd0, 0, 1, "dn0");
        cyc(0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 8'd0, 1, 1, "dn_sat1");
        cyc(0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 8'd0, 1, 1, "dn_sat2");
        cyc(0, 0, 8'd0, 0, 0, 8'd5, 0, 1, 8'd0, 0, 0, "clr_ovf");
        // Set wins over clear
        cyc(0, 0, 8'd0, 1, 0, 8'd5, 0, 1, 8'd0, 1, 1, "set_over_clr");
        cyc(0, 0, 8'd0, 0, 0, 8'd5, 0, 1, 8'd0, 0, 0, "clr_again");

        // Load clamps to limit and suppresses the step
        cyc(0, 1, 8'd200, 1, 1, 8'd100, 1, 0, 8'd100, 0, 0, "load_clamp");
        cyc(0, 0, 8'd0, 0, 1, 8'd100, 1, 0, 8'd100, 0, 0, "load_hold");

        // Limit lowered below count
        cyc(0, 1, 8'd50, 0, 0, 8'd100, 1, 0, 8'd50, 0, 0, "load50");
        cyc(0, 0, 8'd0, 1, 0, 8'd10, 1, 0, 8'd10, 0, 0, "lim_lowered");
        cyc(0, 0, 8'd0, 1, 1, 8'd10, 1, 0, 8'd0, 1, 1, "lim_up_wrap");

        // Saturate up
        cyc(0, 1, 8'd2, 0, 1, 8'd3, 0, 1, 8'd2, 0, 0, "sat_load");
        cyc(0, 0, 8'd0, 1, 1, 8'd3, 0, 0, 8'd3, 0, 0, "sat_to_lim");
        cyc(0, 0, 8'd0, 1, 1, 8'd3, 0, 0, 8'd3, 1, 1, "sat_b1");
        cyc(0, 0, 8'd0, 1, 1, 8'd3, 0, 0, 8'd3, 1, 1, "sat_b2");
        cyc(0, 0, 8'd0, 0, 1, 8'd3, 0, 0, 8'd3, 0, 1, "sat_idle");

        // Down wrap to limit
        cyc(0, 1, 8'd0, 0, 0, 8'd7, 1, 1, 8'd0, 0, 0, "dwrap_load");
        cyc(0, 0, 8'd0, 1, 0, 8'd7, 1, 0, 8'd7, 1, 1, "dwrap");
        cyc(0, 0, 8'd0, 1, 0, 8'd7, 1, 0, 8'd6, 0, 1, "dwrap_next");

        // limit = 0: every step is a boundary
        cyc(0, 1, 8'd4, 0, 1, 8'd0, 1, 1, 8'd0, 0, 0, "l0_load");
        cyc(0, 0, 8'd0, 1, 1, 8'd0, 1, 0, 8'd0, 1, 1, "l0_up");
        cyc(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 8'd0, 1, 1, "l0_dn");
        cyc(0, 0, 8'd0, 0, 0, 8'd0, 1, 0, 8'd0, 0, 1, "l0_idle");

        // Full-range wrap, no carry out
        cyc(0, 1, 8'd255, 0, 1, 8'd255, 1, 1, 8'd255, 0, 0, "full_load");
        cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd0, 1, 1, "full_wrap");

        // Reset mid-run
        cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd1, 0, 1, "pre_rst_step");
        cyc(1, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd0, 0, 0, "mid_rst");
        cyc(0, 0, 8'd0, 1, 1, 8'd255, 1, 0, 8'd1, 0, 0, "post_rst");
`endif

        stim_done = 1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
